// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: a program is written through the load port at run time,
// and fetches return one registered word per accepted request. Optional parity: IMEM_PARITY_EN.
module instr_mem_loadable #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int LA_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_fault,
  input  logic              load_en,
  input  logic [LA_W-1:0]   load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
`ifdef IMEM_PARITY_EN
  output logic              parity_err,
`endif
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic              par_mem [DEPTH];
`endif

  logic              accept;
  logic [LA_W-1:0]   word_idx;
  logic [ADDR_W-1:0] high_bits;
  logic              bad_addr;
  logic [DATA_W-1:0] rd_word;

  assign fetch_ready = (state_q == RUN) && !load_en;
  assign accept      = fetch_req && fetch_ready;
  assign state_o     = state_q;

  // Any bit above the array's byte span means out of range; addresses never alias.
  assign word_idx  = fetch_addr[LA_W+1:2];
  assign high_bits = fetch_addr >> (LA_W + 2);
  assign bad_addr  = (fetch_addr[1:0] != 2'b00) || (high_bits != '0);
  assign rd_word   = mem[word_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // load_done wins over load_en, so a final write with load_done lands and enters RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (load_done)    state_d = RUN;
        else if (load_en) state_d = LOAD;
      end
      LOAD: begin
        if (load_done) state_d = RUN;
      end
      RUN: begin
        if (load_done)    state_d = RUN;
        else if (load_en) state_d = LOAD;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
`ifdef IMEM_PARITY_EN
      par_mem[load_addr] <= ^load_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      instr_valid <= accept;
      if (accept) begin
        if (bad_addr) begin
          instr       <= '0;
          fetch_fault <= 1'b1;
        end else begin
          instr       <= rd_word;
          fetch_fault <= 1'b0;
        end
      end
    end
  end

`ifdef IMEM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (accept) begin
      parity_err <= !bad_addr && ((^rd_word) != par_mem[word_idx]);
    end
  end
`endif

endmodule
